bsg_manycore_pod_reset_tag_sequencer: RTL

//  Transmit side of the per-pod bsg_tag reset path. Turns pod-reset commands into serial bsg_tag packets,
//  one per pod tag client (one client per pod, payload = pod reset bit), on a single tag data line.

---
 rtl/bsg_manycore_pod_reset_tag_sequencer_if.sv | 29 ++
 rtl/bsg_manycore_pod_reset_tag_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_pod_reset_tag_sequencer_if.sv
// Command handshake bundle for the pod reset tag sequencer.
// Handshake: a command transfers on a rising clock edge where v_i and ready_o are both 1.
// cmd_i, pod_id_i and reset_val_i are only meaningful while v_i is 1.
// ready_o never depends on v_i.
interface bsg_manycore_pod_reset_tag_sequencer_if #(
    parameter int pod_id_w_p = 1
);
    logic                  v_i;
    logic                  ready_o;
    logic [1:0]            cmd_i;
    logic [pod_id_w_p-1:0] pod_id_i;
    logic                  reset_val_i;

    modport master (
        output v_i,
        output cmd_i,
        output pod_id_i,
        output reset_val_i,
        input  ready_o
    );

    modport slave (
        input  v_i,
        input  cmd_i,
        input  pod_id_i,
        input  reset_val_i,
        output ready_o
    );
endinterface

// File: rtl/bsg_manycore_pod_reset_tag_sequencer.sv
// Pod reset bsg_tag transmitter: turns pod reset commands into serial tag
// packets, one per pod client, sent LSB first on a single data line.
// Packet fields from bit 0 upward: start(1) | len | data_not_reset | node_id | payload.
module bsg_manycore_pod_reset_tag_sequencer #(
    parameter int num_pods_x_p     = 1,
    parameter int num_pods_y_p     = 1,
    parameter int tag_els_p        = 16,
    parameter int tag_lg_width_p   = 4,
    parameter int node_id_offset_p = 0,
    parameter int payload_width_p  = 1,
    parameter int gap_cycles_p     = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    bsg_manycore_pod_reset_tag_sequencer_if.slave     cmd_if,
    output logic                                      tag_data_o,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic [2:0]                                state_o
);

    localparam int npods_lp      = num_pods_x_p * num_pods_y_p;
    localparam int id_w_lp       = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
    localparam int pod_id_w_lp   = (npods_lp > 1) ? $clog2(npods_lp) : 1;
    localparam int pod_cnt_w_lp  = $clog2(npods_lp + 1);
    localparam int pkt_len_lp    = 2 + tag_lg_width_p + id_w_lp + payload_width_p;
    localparam int cnt_max_lp    = (pkt_len_lp > gap_cycles_p) ? pkt_len_lp : gap_cycles_p;
    localparam int cnt_w_lp      = $clog2(cnt_max_lp + 1);

    // Field positions inside the packet
    localparam int len_pos_lp    = 1;
    localparam int dnr_pos_lp    = 1 + tag_lg_width_p;
    localparam int id_pos_lp     = 2 + tag_lg_width_p;
    localparam int pay_pos_lp    = 2 + tag_lg_width_p + id_w_lp;

    localparam logic [1:0] cmd_clear_lp    = 2'd0;
    localparam logic [1:0] cmd_assert_lp   = 2'd1;
    localparam logic [1:0] cmd_deassert_lp = 2'd2;
    localparam logic [1:0] cmd_single_lp   = 2'd3;

    typedef enum logic [2:0] {
        S_FLUSH = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e                  state_r, state_n;
    logic [cnt_w_lp-1:0]     cnt_r, cnt_n;
    logic [pod_cnt_w_lp-1:0] pod_cnt_r, pod_cnt_n;
    logic [pkt_len_lp-1:0]   shreg_r, shreg_n;
    logic [1:0]              cmd_r, cmd_n;
    logic [pod_id_w_lp-1:0]  pod_id_r, pod_id_n;
    logic                    reset_val_r, reset_val_n;

    logic                    is_single;
    logic                    pod_in_range;
    logic [31:0]             pod_sel;
    logic [id_w_lp-1:0]      node_id;
    logic                    pay_bit;
    logic                    dnr_bit;
    logic [pkt_len_lp-1:0]   pkt;
    logic                    ready;

    // Packet contents for the pod currently being addressed
    always_comb begin
        is_single    = (cmd_r == cmd_single_lp);
        pod_in_range = (32'(pod_id_r) < 32'(npods_lp));
        pod_sel      = is_single ? 32'(pod_id_r) : 32'(pod_cnt_r);
        node_id      = id_w_lp'(32'(node_id_offset_p) + pod_sel);
        dnr_bit      = (cmd_r != cmd_clear_lp);
        case (cmd_r)
            cmd_assert_lp:   pay_bit = 1'b1;
            cmd_deassert_lp: pay_bit = 1'b0;
            cmd_single_lp:   pay_bit = reset_val_r;
            default:         pay_bit = 1'b0;
        endcase
        pkt                                  = '0;
        pkt[0]                               = 1'b1;
        pkt[len_pos_lp +: tag_lg_width_p]    = tag_lg_width_p'(payload_width_p);
        pkt[dnr_pos_lp]                      = dnr_bit;
        pkt[id_pos_lp +: id_w_lp]            = node_id;
        pkt[pay_pos_lp]                      = pay_bit;
    end

    // Next-state, counter and output decode
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        pod_cnt_n   = pod_cnt_r;
        shreg_n     = shreg_r;
        cmd_n       = cmd_r;
        pod_id_n    = pod_id_r;
        reset_val_n = reset_val_r;
        ready       = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        tag_data_o  = 1'b0;

        case (state_r)
            S_FLUSH: begin
                // Zeros after reset let the receiver discard any truncated packet
                if (cnt_r == cnt_w_lp'(gap_cycles_p - 1)) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_r + cnt_w_lp'(1);
                end
            end
            S_IDLE: begin
                ready  = 1'b1;
                busy_o = 1'b0;
                if (cmd_if.v_i) begin
                    cmd_n       = cmd_if.cmd_i;
                    pod_id_n    = cmd_if.pod_id_i;
                    reset_val_n = cmd_if.reset_val_i;
                    pod_cnt_n   = '0;
                    cnt_n       = '0;
                    state_n     = S_LOAD;
                end
            end
            S_LOAD: begin
                // An out-of-range single pod sends nothing but still completes
                if (is_single && !pod_in_range) begin
                    state_n = S_DONE;
                end else begin
                    shreg_n = pkt;
                    cnt_n   = '0;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                tag_data_o = shreg_r[0];
                shreg_n    = shreg_r >> 1;
                if (cnt_r == cnt_w_lp'(pkt_len_lp - 1)) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt_r + cnt_w_lp'(1);
                end
            end
            S_GAP: begin
                if (cnt_r == cnt_w_lp'(gap_cycles_p - 1)) begin
                    cnt_n = '0;
                    if (is_single || (pod_cnt_r == pod_cnt_w_lp'(npods_lp - 1))) begin
                        state_n = S_DONE;
                    end else begin
                        pod_cnt_n = pod_cnt_r + pod_cnt_w_lp'(1);
                        state_n   = S_LOAD;
                    end
                end else begin
                    cnt_n = cnt_r + cnt_w_lp'(1);
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_FLUSH;
                cnt_n   = '0;
            end
        endcase
    end

    // State and datapath registers; reset lands in FLUSH with the line low
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= S_FLUSH;
            cnt_r       <= '0;
            pod_cnt_r   <= '0;
            shreg_r     <= '0;
            cmd_r       <= '0;
            pod_id_r    <= '0;
            reset_val_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            pod_cnt_r   <= pod_cnt_n;
            shreg_r     <= shreg_n;
            cmd_r       <= cmd_n;
            pod_id_r    <= pod_id_n;
            reset_val_r <= reset_val_n;
        end
    end

    assign cmd_if.ready_o = ready;
    assign state_o        = state_r;

endmodule
